// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: FSM state encoding,
// RV32 base opcodes, writeback mux select codes and PC source codes.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Writeback mux select (codes 4-7 are never driven)
  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;

  // PC source select
  localparam logic [1:0] PCS_PC4          = 2'd0;
  localparam logic [1:0] PCS_TARGET       = 2'd1;
  localparam logic [1:0] PCS_TARGET_ALIGN = 2'd2;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_MISC_MEM: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RV32 base-ISA control FSM.
// Inputs : clock, reset_n (sync, active-low), fetch_opcode[6:0],
//          branch_taken, mem_ready.
// Outputs: memory strobes (mem_read, mem_write, mem_addr_sel), ir_write,
//          reg_write, writeback_sel[2:0], pc_write, pc_source_sel[1:0],
//          alu_a_sel, alu_b_sel, illegal (sticky), state[2:0] (debug),
//          instret[31:0] (retired-instruction count).
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  fetch_opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        reg_write,
  output logic [2:0]  writeback_sel,
  output logic        pc_write,
  output logic [1:0]  pc_source_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [6:0]  opcode_q;
  logic        illegal_q;
  logic [31:0] instret_q;

  logic mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw, pc_write_raw;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  // Latched opcode, sticky illegal flag and retire counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state_q == ST_FETCH && mem_ready) opcode_q <= fetch_opcode;
      if (state_d == ST_TRAP)               illegal_q <= 1'b1;
      if (pc_write)                         instret_q <= instret_q + 32'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = is_legal(opcode_q) ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        case (opcode_q)
          OPC_LOAD, OPC_STORE:      state_d = ST_MEMORY;
          OPC_BRANCH, OPC_MISC_MEM: state_d = ST_FETCH;
          default:                  state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        if (mem_ready) state_d = (opcode_q == OPC_LOAD) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    writeback_sel = WB_ALU;
    pc_write_raw  = 1'b0;
    pc_source_sel = PCS_PC4;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_raw = 1'b1;
        ir_write_raw = mem_ready;
      end
      ST_EXECUTE: begin
        alu_a_sel = (opcode_q == OPC_AUIPC) || (opcode_q == OPC_JAL) ||
                    (opcode_q == OPC_BRANCH);
        alu_b_sel = !((opcode_q == OPC_OP) || (opcode_q == OPC_BRANCH));
        // Branches and fences retire here
        if (opcode_q == OPC_BRANCH || opcode_q == OPC_MISC_MEM) begin
          pc_write_raw = 1'b1;
          if (opcode_q == OPC_BRANCH && branch_taken) pc_source_sel = PCS_TARGET;
        end
      end
      ST_MEMORY: begin
        mem_addr_sel  = 1'b1;
        mem_read_raw  = (opcode_q == OPC_LOAD);
        mem_write_raw = (opcode_q == OPC_STORE);
        // Stores retire on the completing memory cycle
        pc_write_raw  = (opcode_q == OPC_STORE) && mem_ready;
      end
      ST_WRITEBACK: begin
        reg_write_raw = 1'b1;
        pc_write_raw  = 1'b1;
        case (opcode_q)
          OPC_LOAD:           writeback_sel = WB_MEM;
          OPC_JAL, OPC_JALR:  writeback_sel = WB_PC4;
          OPC_LUI:            writeback_sel = WB_IMM;
          default:            writeback_sel = WB_ALU;
        endcase
        case (opcode_q)
          OPC_JAL:  pc_source_sel = PCS_TARGET;
          OPC_JALR: pc_source_sel = PCS_TARGET_ALIGN;
          default:  pc_source_sel = PCS_PC4;
        endcase
      end
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held
  assign mem_read  = mem_read_raw  & reset_n;
  assign mem_write = mem_write_raw & reset_n;
  assign ir_write  = ir_write_raw  & reset_n;
  assign reg_write = reg_write_raw & reset_n;
  assign pc_write  = pc_write_raw  & reset_n;

  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [6:0]  fetch_opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_read, mem_write, mem_addr_sel, ir_write, reg_write;
  logic [2:0]  writeback_sel;
  logic        pc_write;
  logic [1:0]  pc_source_sel;
  logic        alu_a_sel, alu_b_sel, illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clock = ~clock;

  multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .fetch_opcode(fetch_opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .reg_write(reg_write), .writeback_sel(writeback_sel),
    .pc_write(pc_write), .pc_source_sel(pc_source_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .illegal(illegal),
    .state(state), .instret(instret)
  );

  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OP = 7'h33, OP_IMM = 7'h13;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63, MISC = 7'h0F, BAD = 7'h7F;

  typedef enum int {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} phase_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        mrd, mwr, mas, irw, rgw;
    logic [2:0]  wbs;
    logic        pcw;
    logic [1:0]  pcs;
    logic        aa, ab, ill;
    logic [31:0] ir;
  } vec_t;

  typedef struct packed {
    int unsigned lat;
    logic [1:0]  pcs;
  } ret_t;

  vec_t cyc_q[$];
  ret_t ret_q[$];
  int checks = 0;
  int failures = 0;
  int unsigned retired = 0;
  int unsigned lat_cnt = 0;
  int unsigned cyc = 0;
  logic finish_req = 1'b0;
  vec_t e, a;
  ret_t r;
  logic [6:0] legal_ops [10] = '{LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, MISC};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected control outputs for one cycle, from the instruction-level rules
  function automatic vec_t model(phase_t ph, logic [6:0] op, logic mr, logic bt,
                                 logic rst, int unsigned ret);
    vec_t v;
    v = '0;
    v.ir = 32'(ret);
    case (ph)
      P_FETCH:  begin v.st = 3'd0; v.mrd = 1'b1; v.irw = mr; end
      P_DECODE: v.st = 3'd1;
      P_EXEC: begin
        v.st = 3'd2;
        v.aa = (op == AUIPC || op == JAL || op == BRANCH);
        v.ab = !(op == OP || op == BRANCH);
        if (op == BRANCH || op == MISC) begin
          v.pcw = 1'b1;
          v.pcs = (op == BRANCH && bt) ? 2'd1 : 2'd0;
        end
      end
      P_MEM: begin
        v.st = 3'd3; v.mas = 1'b1;
        v.mrd = (op == LOAD); v.mwr = (op == STORE);
        v.pcw = (op == STORE) && mr;
      end
      P_WB: begin
        v.st = 3'd4; v.rgw = 1'b1; v.pcw = 1'b1;
        v.wbs = (op == LOAD) ? 3'd1 : (op == JAL || op == JALR) ? 3'd2 :
                (op == LUI) ? 3'd3 : 3'd0;
        v.pcs = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
      end
      P_TRAP: begin v.st = 3'd7; v.ill = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      v.mrd = 1'b0; v.mwr = 1'b0; v.irw = 1'b0; v.rgw = 1'b0; v.pcw = 1'b0;
    end
    return v;
  endfunction

  task automatic drive_cycle(input phase_t ph, input logic [6:0] op, input logic mr,
                             input logic bt, input logic rst);
    vec_t v;
    reset_n      = !rst;
    mem_ready    = mr;
    branch_taken = bt;
    fetch_opcode = (ph == P_FETCH && mr) ? op : 7'($urandom);
    v = model(ph, op, mr, bt, rst, retired);
    cyc_q.push_back(v);
    @(posedge clock);
    #1;
    if (rst)        retired = 0;
    else if (v.pcw) retired = retired + 1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int unsigned fs,
                           input int unsigned ms, input logic bt);
    logic is_mem, has_wb;
    ret_t rr;
    is_mem = (op == LOAD || op == STORE);
    has_wb = !(op == BRANCH || op == MISC || op == STORE);
    rr.lat = 3 + fs + (is_mem ? ms + 1 : 0) + (has_wb ? 1 : 0);
    rr.pcs = (op == JAL || (op == BRANCH && bt)) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
    ret_q.push_back(rr);
    for (int unsigned i = 0; i < fs; i++) drive_cycle(P_FETCH, op, 1'b0, rb(), 1'b0);
    drive_cycle(P_FETCH, op, 1'b1, rb(), 1'b0);
    drive_cycle(P_DECODE, op, rb(), rb(), 1'b0);
    drive_cycle(P_EXEC, op, rb(), bt, 1'b0);
    if (is_mem) begin
      for (int unsigned i = 0; i < ms; i++) drive_cycle(P_MEM, op, 1'b0, rb(), 1'b0);
      drive_cycle(P_MEM, op, 1'b1, rb(), 1'b0);
    end
    if (has_wb) drive_cycle(P_WB, op, rb(), rb(), 1'b0);
  endtask

  // Monitor: per-cycle control vector, and retire events on pc_write
  always @(negedge clock) begin
    cyc++;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      a = {state, mem_read, mem_write, mem_addr_sel, ir_write, reg_write, writeback_sel,
           pc_write, pc_source_sel, alu_a_sel, alu_b_sel, illegal, instret};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctrl_vec cyc=%0d got st=%0d rd=%b wr=%b as=%b irw=%b rw=%b wbs=%0d pcw=%b pcs=%0d aa=%b ab=%b ill=%b ir=%0d | exp st=%0d rd=%b wr=%b as=%b irw=%b rw=%b wbs=%0d pcw=%b pcs=%0d aa=%b ab=%b ill=%b ir=%0d",
                 cyc, a.st, a.mrd, a.mwr, a.mas, a.irw, a.rgw, a.wbs, a.pcw, a.pcs, a.aa, a.ab, a.ill, a.ir,
                 e.st, e.mrd, e.mwr, e.mas, e.irw, e.rgw, e.wbs, e.pcw, e.pcs, e.aa, e.ab, e.ill, e.ir);
      end
    end
    if (reset_n !== 1'b1) begin
      lat_cnt = 0;
    end else begin
      lat_cnt++;
      if (pc_write === 1'b1) begin
        checks++;
        if (ret_q.size() == 0) begin
          failures++;
          $display("FAIL retire_unexpected cyc=%0d got pc_write=1 exp no retire", cyc);
        end else begin
          r = ret_q.pop_front();
          if (r.lat != lat_cnt || r.pcs !== pc_source_sel) begin
            failures++;
            $display("FAIL retire cyc=%0d got lat=%0d pcs=%0d exp lat=%0d pcs=%0d",
                     cyc, lat_cnt, pc_source_sel, r.lat, r.pcs);
          end
        end
        lat_cnt = 0;
      end
    end
    if (finish_req) begin
      checks++;
      if (cyc_q.size() != 0 || ret_q.size() != 0) begin
        failures++;
        $display("FAIL drain got cyc_q=%0d ret_q=%0d exp 0 0", cyc_q.size(), ret_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    logic [6:0] op;
    int unsigned fs, ms;
    reset_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; fetch_opcode = '0;
    @(posedge clock);
    #1;
    // Held in reset: FETCH, strobes low even with mem_ready high
    drive_cycle(P_FETCH, OP, 1'b1, 1'b0, 1'b1);
    drive_cycle(P_FETCH, OP, 1'b1, 1'b1, 1'b1);

    // Directed instructions
    run_instr(OP, 0, 0, 1'b0);
    run_instr(LOAD, 0, 3, 1'b0);
    run_instr(BRANCH, 0, 0, 1'b1);
    run_instr(BRANCH, 0, 0, 1'b0);
    run_instr(JALR, 0, 0, 1'b0);
    run_instr(STORE, 2, 0, 1'b1);

    // Random instruction stream with random fetch/memory stalls
    for (int n = 0; n < 200; n++) begin
      op = legal_ops[$urandom_range(0, 9)];
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(op, fs, ms, rb());
    end

    // Reset during a stalled STORE memory access
    drive_cycle(P_FETCH, STORE, 1'b1, rb(), 1'b0);
    drive_cycle(P_DECODE, STORE, rb(), rb(), 1'b0);
    drive_cycle(P_EXEC, STORE, rb(), rb(), 1'b0);
    drive_cycle(P_MEM, STORE, 1'b0, rb(), 1'b0);
    drive_cycle(P_MEM, STORE, 1'b0, rb(), 1'b1);
    run_instr(OP_IMM, 0, 0, 1'b0);

    // Illegal opcode traps until reset
    drive_cycle(P_FETCH, BAD, 1'b1, rb(), 1'b0);
    drive_cycle(P_DECODE, BAD, rb(), rb(), 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(P_TRAP, BAD, rb(), rb(), 1'b0);
    drive_cycle(P_TRAP, BAD, 1'b1, rb(), 1'b1);
    run_instr(LUI, 1, 0, 1'b0);
    run_instr(JAL, 0, 0, 1'b1);

    mem_ready = 1'b0;
    finish_req = 1'b1;
  end

endmodule
